// File: rtl/divider_32bit_ctrl_if.sv
// Handshake and result bundle between the ALU sequencer (master) and the
// multi-cycle divider (slave).
interface divider_32bit_ctrl_if;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/divider_32bit_ctrl.sv
// Multi-cycle restoring divider: one shared 32-bit subtractor, one quotient
// bit per cycle, with signed magnitude conversion and sign fix-up.

module subtractor_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] diff
);
  assign diff = a - b;
endmodule

module divider_32bit_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  divider_32bit_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_ITER  = 3'd2,
    S_FIXUP = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   dvd_r;
  logic [WIDTH-1:0]   dvs_r;
  logic [WIDTH-1:0]   q_r;
  logic [WIDTH-1:0]   rem_r;
  logic               sgn_r;
  logic               neg_q_r;
  logic               neg_r_r;
  logic               busy_r;
  logic               done_r;
  logic               dbz_r;
  logic [WIDTH-1:0]   quotient_r;
  logic [WIDTH-1:0]   remainder_r;

  logic [WIDTH-1:0]   shifted_s;
  logic [WIDTH-1:0]   diff_s;
  logic               borrow_s;
  logic [WIDTH-1:0]   q_fix_s;
  logic [WIDTH-1:0]   r_fix_s;
  logic               dvs_zero_s;

  function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] v);
    return (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? twos_neg(v) : v;
  endfunction

  // The shift-in bit comes from the dividend bits still parked in q_r.
  assign shifted_s  = {rem_r[WIDTH-2:0], q_r[WIDTH-1]};
  assign dvs_zero_s = (dvs_r == {WIDTH{1'b0}});

  subtractor_32bit u_sub (
    .a    (shifted_s),
    .b    (dvs_r),
    .diff (diff_s)
  );

  assign borrow_s = (~shifted_s[WIDTH-1] & dvs_r[WIDTH-1]) |
                    (~(shifted_s[WIDTH-1] ^ dvs_r[WIDTH-1]) & diff_s[WIDTH-1]);

  assign q_fix_s = (sgn_r && neg_q_r) ? twos_neg(q_r)   : q_r;
  assign r_fix_s = (sgn_r && neg_r_r) ? twos_neg(rem_r) : rem_r;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (bus.start) state_s = S_SETUP;
        else           state_s = S_IDLE;
      end
      S_SETUP: begin
        if (dvs_zero_s) state_s = S_DONE;
        else            state_s = S_ITER;
      end
      S_ITER: begin
        if (cnt_r == {{(CNT_W-1){1'b0}}, 1'b1}) state_s = S_FIXUP;
        else                                    state_s = S_ITER;
      end
      S_FIXUP: state_s = S_DONE;
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r       <= {CNT_W{1'b0}};
      dvd_r       <= {WIDTH{1'b0}};
      dvs_r       <= {WIDTH{1'b0}};
      q_r         <= {WIDTH{1'b0}};
      rem_r       <= {WIDTH{1'b0}};
      sgn_r       <= 1'b0;
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
      dbz_r       <= 1'b0;
      quotient_r  <= {WIDTH{1'b0}};
      remainder_r <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.start) begin
            dvd_r <= bus.dividend;
            dvs_r <= bus.divisor;
            sgn_r <= bus.is_signed;
            dbz_r <= 1'b0;
          end
        end
        S_SETUP: begin
          if (dvs_zero_s) begin
            quotient_r  <= {WIDTH{1'b1}};
            remainder_r <= dvd_r;
            dbz_r       <= 1'b1;
          end else begin
            q_r     <= magnitude(dvd_r, sgn_r);
            dvs_r   <= magnitude(dvs_r, sgn_r);
            neg_q_r <= dvd_r[WIDTH-1] ^ dvs_r[WIDTH-1];
            neg_r_r <= dvd_r[WIDTH-1];
            rem_r   <= {WIDTH{1'b0}};
            cnt_r   <= CNT_W'(WIDTH);
          end
        end
        S_ITER: begin
          rem_r <= borrow_s ? shifted_s : diff_s;
          q_r   <= {q_r[WIDTH-2:0], ~borrow_s};
          cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
        S_FIXUP: begin
          quotient_r  <= q_fix_s;
          remainder_r <= r_fix_s;
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Status flags track the state being entered so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_s == S_SETUP) || (state_s == S_ITER) || (state_s == S_FIXUP);
      done_r <= (state_s == S_DONE);
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_divider_32bit_ctrl.sv
// Randomized and directed bench for divider_32bit_ctrl against an arithmetic
// reference model.
module tb_divider_32bit_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  divider_32bit_ctrl_if bus ();

  divider_32bit_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected result from plain integer arithmetic.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r, output logic z);
    z = 1'b0;
    if (b == 32'd0) begin
      q = 32'hFFFFFFFF; r = a; z = 1'b1;
    end else if (s) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
        q = 32'h80000000; r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Accepting edge is N; done is expected in cycle N+35 (34 edges later), or N+2 for /0.
  function automatic int ref_lat(input logic [31:0] b);
    return (b == 32'd0) ? 1 : 34;
  endfunction

  // Issue one operation from IDLE and collect what the DUT reports.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output int lat, output logic [31:0] q, output logic [31:0] r,
                        output logic z, output logic busy_ok, output logic pulse_ok);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b; bus.is_signed = s;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.dividend = $urandom; bus.divisor = $urandom; bus.is_signed = 1'b0;
    lat = 0; busy_ok = 1'b1;
    while (!bus.done && lat < 100) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (bus.busy) busy_ok = 1'b0;
    q = bus.quotient; r = bus.remainder; z = bus.div_by_zero;
    @(posedge clk); #1;
    pulse_ok = !bus.done;
  endtask

  task automatic check_op(input string name, input logic [31:0] a, input logic [31:0] b, input logic s);
    int lat; logic [31:0] q, r, eq, er; logic z, ez, bok, pok;
    ref_div(a, b, s, eq, er, ez);
    run_op(a, b, s, lat, q, r, z, bok, pok);
    checks++;
    if ({q, r, z} !== {eq, er, ez}) begin
      errors++;
      $display("FAIL %s result a=%h b=%h s=%0d got q=%h r=%h z=%0d want q=%h r=%h z=%0d",
               name, a, b, s, q, r, z, eq, er, ez);
    end
    checks++;
    if (lat !== ref_lat(b)) begin
      errors++;
      $display("FAIL %s latency a=%h b=%h got %0d want %0d", name, a, b, lat, ref_lat(b));
    end
    checks++;
    if ({bok, pok} !== 2'b11) begin
      errors++;
      $display("FAIL %s busy/pulse got busy_ok=%0d pulse_ok=%0d want 1 1", name, bok, pok);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== 67'd0) begin
      errors++;
      $display("FAIL reset_state got busy=%0d done=%0d q=%h r=%h z=%0d want all 0",
               bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    check_op("100/7s",     32'd100,        32'd7,          1'b1);
    check_op("-100/7s",    32'hFFFFFF9C,   32'd7,          1'b1);
    check_op("max/2u",     32'hFFFFFFFF,   32'd2,          1'b0);
    check_op("-1/2s",      32'hFFFFFFFF,   32'd2,          1'b1);
    check_op("5/0",        32'd5,          32'd0,          1'b0);
    check_op("min/-1s",    32'h80000000,   32'hFFFFFFFF,   1'b1);
    check_op("min/1s",     32'h80000000,   32'd1,          1'b1);
    check_op("7/100u",     32'd7,          32'd100,        1'b0);
    check_op("x/minu",     32'hFFFFFFFF,   32'h80000000,   1'b0);
    check_op("0/0s",       32'd0,          32'd0,          1'b1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    logic s;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1, 2, 3: b = $urandom_range(1, 15);
        4:       b = 32'd0 - $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      s = $urandom_range(0, 1);
      check_op("random", a, b, s);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.dividend = 32'd100; bus.divisor = 32'd7; bus.is_signed = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 100) begin
      if (lat == 6) begin
        bus.start = 1'b1; bus.dividend = 32'd9; bus.divisor = 32'd3;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    checks++;
    if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {32'd14, 32'd2, 1'b0}) begin
      errors++;
      $display("FAIL ignore_start got q=%h r=%h z=%0d want q=0000000e r=00000002 z=0",
               bus.quotient, bus.remainder, bus.div_by_zero);
    end
    checks++;
    if (lat !== 34) begin
      errors++;
      $display("FAIL ignore_start_latency got %0d want 34", lat);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start_not_queued got busy=%0d want 0", bus.busy);
    end
  endtask

  task automatic test_reset_abort();
    logic saw_done;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.dividend = 32'd100; bus.divisor = 32'd7; bus.is_signed = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== 67'd0) begin
      errors++;
      $display("FAIL reset_abort got busy=%0d done=%0d q=%h r=%h z=%0d want all 0",
               bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort_no_done got activity=%0d want 0", saw_done);
    end
    check_op("after_abort", 32'hFFFFFF9C, 32'd7, 1'b1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.start = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend = 32'd0;
    bus.divisor = 32'd0;
    reset = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_ignore_start();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
